// File: rtl/simon_pkg.sv
// Shared types and sizes for the Simon game sequencer and its memory bus.
package simon_pkg;
  localparam int ADDR_W    = 4;
  localparam int MEM_DEPTH = 10;

  typedef logic [1:0] colour_t;

  typedef enum logic [3:0] {
    IDLE,
    APPEND,
    PLAY_RD,
    PLAY_LAT,
    PLAY_ON,
    PLAY_GAP,
    INPUT,
    CHK_LAT,
    WIN,
    LOSE
  } state_t;
endpackage

// File: rtl/simon_if.sv
// Sequence-memory bus: the sequencer drives address/rw/write data, the memory returns read data.
interface simon_if;
  import simon_pkg::*;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_rw;
  colour_t           mem_in_num;
  colour_t           mem_out_num;

  modport master (output mem_address, mem_rw, mem_in_num, input mem_out_num);
  modport slave  (input mem_address, mem_rw, mem_in_num, output mem_out_num);
endinterface

// File: rtl/simon_lfsr.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1, stepping toward bit 0 when enabled.
module simon_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_step,
  output logic [7:0] o_state
);
  localparam logic [7:0] TAPS = 8'hB8;

  logic [7:0] r_state;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= SEED;
    end else if (i_step) begin
      r_state <= {1'b0, r_state[7:1]} ^ (r_state[0] ? TAPS : 8'h00);
    end
  end

  assign o_state = r_state;
endmodule

// File: rtl/simon_sequencer.sv
// Simon game controller: appends one random colour per round, replays it, checks presses.
// Optional build macro INPUT_TIMEOUT_EN: lose after TIMEOUT_CYCLES idle cycles in INPUT.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int         MAX_LEN        = MEM_DEPTH,
  parameter int         ON_CYCLES      = 8,
  parameter int         GAP_CYCLES     = 4,
  parameter logic [7:0] SEED           = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       btn_valid,
  input  colour_t    btn_num,
  simon_if.master    mem,
  output logic       led_en,
  output colour_t    led_num,
  output logic [3:0] round,
  output logic       busy,
  output logic       win,
  output logic       lose
);
  // state    | meaning
  // IDLE     | waiting for start
  // APPEND   | write next random colour at address len
  // PLAY_RD  | present replay read address
  // PLAY_LAT | capture read data onto the LED
  // PLAY_ON  | LED lit
  // PLAY_GAP | LED dark between colours
  // INPUT    | waiting for a press
  // CHK_LAT  | compare press with stored colour
  // WIN/LOSE | terminal, waiting for start

  localparam int T_A     = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int T_MAX   = (T_A > TIMEOUT_CYCLES) ? T_A : TIMEOUT_CYCLES;
  localparam int TIMER_W = $clog2(T_MAX + 1);
  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] T_ZERO   = '0;
  localparam logic [3:0]         LEN_MAX  = 4'(MAX_LEN);
`ifdef INPUT_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] TO_LOAD  = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t               r_state, w_state;
  logic [3:0]           r_len, w_len, r_idx, w_idx;
  logic [TIMER_W-1:0]   r_timer, w_timer;
  colour_t              r_press, w_press, r_led_num, w_led_num;
  logic                 r_led_en, w_led_en, r_win, w_win, r_lose, w_lose;
  logic [ADDR_W-1:0]    r_addr, w_addr;
  logic                 w_rw, w_step;
  colour_t              w_wdata;
  logic [7:0]           w_lfsr;
  logic                 w_unused_lfsr;

  simon_lfsr #(.SEED(SEED)) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_step  (w_step),
    .o_state (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[7:2];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      r_timer   <= '0;
      r_press   <= '0;
      r_led_num <= '0;
      r_led_en  <= 1'b0;
      r_win     <= 1'b0;
      r_lose    <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state;
      r_len     <= w_len;
      r_idx     <= w_idx;
      r_timer   <= w_timer;
      r_press   <= w_press;
      r_led_num <= w_led_num;
      r_led_en  <= w_led_en;
      r_win     <= w_win;
      r_lose    <= w_lose;
      r_addr    <= w_addr;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_len     = r_len;
    w_idx     = r_idx;
    w_timer   = r_timer;
    w_press   = r_press;
    w_led_num = r_led_num;
    w_led_en  = r_led_en;
    w_win     = r_win;
    w_lose    = r_lose;
    w_addr    = r_addr;
    w_rw      = 1'b0;
    w_wdata   = 2'b00;
    w_step    = 1'b0;
    case (r_state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          w_state = APPEND;
          w_len   = '0;
          w_win   = 1'b0;
          w_lose  = 1'b0;
        end
      end
      APPEND: begin
        w_rw    = 1'b1;
        w_addr  = r_len;
        w_wdata = w_lfsr[1:0];
        w_step  = 1'b1;
        w_len   = r_len + 4'd1;
        w_idx   = '0;
        w_state = PLAY_RD;
      end
      PLAY_RD: begin
        w_addr  = r_idx;
        w_state = PLAY_LAT;
      end
      PLAY_LAT: begin
        w_led_num = mem.mem_out_num;
        w_led_en  = 1'b1;
        w_timer   = ON_LOAD;
        w_state   = PLAY_ON;
      end
      PLAY_ON: begin
        if (r_timer == T_ZERO) begin
          w_led_en = 1'b0;
          w_timer  = GAP_LOAD;
          w_state  = PLAY_GAP;
        end else begin
          w_timer = r_timer - T_ONE;
        end
      end
      PLAY_GAP: begin
        if (r_timer != T_ZERO) begin
          w_timer = r_timer - T_ONE;
        end else if (r_idx + 4'd1 == r_len) begin
          w_idx   = '0;
          w_state = INPUT;
`ifdef INPUT_TIMEOUT_EN
          w_timer = TO_LOAD;
`endif
        end else begin
          w_idx   = r_idx + 4'd1;
          w_state = PLAY_RD;
        end
      end
      INPUT: begin
        // Read is presented every cycle here; only the one after a press is consumed.
        w_addr = r_idx;
        if (btn_valid) begin
          w_press = btn_num;
          w_state = CHK_LAT;
`ifdef INPUT_TIMEOUT_EN
        end else if (r_timer == T_ZERO) begin
          w_lose  = 1'b1;
          w_state = LOSE;
        end else begin
          w_timer = r_timer - T_ONE;
`endif
        end
      end
      CHK_LAT: begin
        if (mem.mem_out_num != r_press) begin
          w_lose  = 1'b1;
          w_state = LOSE;
        end else if (r_idx + 4'd1 < r_len) begin
          w_idx   = r_idx + 4'd1;
          w_state = INPUT;
`ifdef INPUT_TIMEOUT_EN
          w_timer = TO_LOAD;
`endif
        end else if (r_len == LEN_MAX) begin
          w_win   = 1'b1;
          w_state = WIN;
        end else begin
          w_state = APPEND;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign mem.mem_address = w_addr;
  assign mem.mem_rw      = w_rw;
  assign mem.mem_in_num  = w_wdata;
  assign led_en          = r_led_en;
  assign led_num         = r_led_num;
  assign round           = r_len;
  assign busy            = !(r_state == IDLE || r_state == WIN || r_state == LOSE);
  assign win             = r_win;
  assign lose            = r_lose;
endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: memory model, LED/write monitors, colour model from the LFSR polynomial.
module tb_simon_sequencer;
  import simon_pkg::*;

  localparam int         MAX_LEN        = 3;
  localparam int         ON_CYCLES      = 8;
  localparam int         GAP_CYCLES     = 4;
  localparam int         TIMEOUT_CYCLES = 16;
  localparam logic [7:0] SEED           = 8'hA5;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       btn_valid = 1'b0;
  colour_t    btn_num = 2'b00;
  logic       led_en;
  colour_t    led_num;
  logic [3:0] round;
  logic       busy, win, lose;

  simon_if mif ();

  simon_sequencer #(
    .MAX_LEN(MAX_LEN), .ON_CYCLES(ON_CYCLES), .GAP_CYCLES(GAP_CYCLES),
    .SEED(SEED), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .btn_valid(btn_valid),
    .btn_num(btn_num), .mem(mif), .led_en(led_en), .led_num(led_num),
    .round(round), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clock = ~clock;

  // memory with one-cycle read latency; read data is unknown after a write
  colour_t mem_arr [16];
  always @(posedge clock) begin
    if (mif.mem_rw === 1'b1) begin
      mem_arr[mif.mem_address] <= mif.mem_in_num;
      mif.mem_out_num <= 2'bxx;
    end else begin
      mif.mem_out_num <= mem_arr[mif.mem_address];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int      p_col[$], p_len[$], p_rise[$];
  int      w_addr_q[$], w_data_q[$];
  int      rise_cyc = 0, last_fall = 0;
  colour_t rise_col = 2'b00;
  logic    led_prev = 1'b0;
  bit      rw_seen = 1'b0;

  always @(negedge clock) begin
    if (mif.mem_rw === 1'b1) begin
      rw_seen = 1'b1;
      w_addr_q.push_back(int'(mif.mem_address));
      w_data_q.push_back(int'(mif.mem_in_num));
    end
    if (led_en === 1'b1 && !led_prev) begin
      rise_cyc = cyc;
      rise_col = led_num;
    end
    if (led_en !== 1'b1 && led_prev) begin
      p_col.push_back(int'(rise_col));
      p_len.push_back(cyc - rise_cyc);
      p_rise.push_back(rise_cyc);
      last_fall = cyc;
    end
    led_prev = (led_en === 1'b1);
  end

  int         checks = 0, failures = 0;
  logic [7:0] m_lfsr;
  colour_t    exp_seq[$];

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic [7:0] taps = '0;
    int         ex[4] = '{8, 6, 5, 4};
    foreach (ex[k]) taps[ex[k]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

  task automatic model_append();
    exp_seq.push_back(m_lfsr[1:0]);
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic clear_mon();
    p_col.delete(); p_len.delete(); p_rise.delete();
  endtask

  // Waits for r LED pulses (optionally pressing buttons meanwhile) and checks them.
  task automatic check_playback(input int r, input bit noise);
    int b = 0;
    while (p_col.size() < r && b < 1000) begin
      if (noise && (b % 5 == 2)) begin
        btn_valid = 1'b1;
        btn_num   = colour_t'($urandom_range(0, 3));
      end
      tick();
      btn_valid = 1'b0;
      b++;
    end
    chk("pulse_count", p_col.size(), r);
    chk("write_count", w_addr_q.size(), r);
    if (w_addr_q.size() == r) begin
      chk("write_addr", w_addr_q[r-1], r - 1);
      chk("write_data", w_data_q[r-1], exp_seq[r-1]);
    end
    for (int i = 0; i < r && i < p_col.size(); i++) begin
      chk("pulse_colour", p_col[i], exp_seq[i]);
      chk("pulse_len", p_len[i], ON_CYCLES);
      // dark time = gap cycles plus the read-address and read-latency cycles
      if (i > 0) chk("pulse_gap", p_rise[i] - (p_rise[i-1] + p_len[i-1]), GAP_CYCLES + 2);
    end
  endtask

  task automatic new_game();
    exp_seq.delete();
    w_addr_q.delete(); w_data_q.delete();
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_append();
  endtask

  initial begin
    int b;
    m_lfsr = SEED;

    // reset then idle
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(5);
    chk("rst_led_en", led_en, 0);
    chk("rst_led_num", led_num, 0);
    chk("rst_round", round, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    chk("rst_addr", mif.mem_address, 0);
    chk("rst_in_num", mif.mem_in_num, 0);
    chk("rst_rw_never", rw_seen, 0);

    // full game to a win, dropped presses during playback and in the compare cycle
    tick($urandom_range(0, 3));
    new_game();
    chk("append_busy", busy, 1);
    chk("append_round", round, 0);
    for (int r = 1; r <= MAX_LEN; r++) begin
      check_playback(r, r == MAX_LEN);
      tick(GAP_CYCLES);
      chk("input_busy", busy, 1);
      chk("input_round", round, r);
      chk("input_led_off", led_en, 0);
      for (int i = 0; i < r; i++) begin
        tick($urandom_range(0, 3));
        if (i == r - 1) clear_mon();
        btn_valid = 1'b1;
        btn_num   = exp_seq[i];
        tick();
        btn_valid = 1'b0;
        if (i < r - 1) begin
          btn_valid = 1'b1;
          btn_num   = exp_seq[i] + 2'd1;
          tick();
          btn_valid = 1'b0;
          chk("mid_busy", busy, 1);
          chk("mid_lose", lose, 0);
        end
      end
      if (r < MAX_LEN) model_append();
    end
    chk("prewin_win", win, 0);
    tick();
    chk("win_flag", win, 1);
    chk("win_busy", busy, 0);
    chk("win_round", round, MAX_LEN);
    chk("win_lose", lose, 0);

    // new game, wrong first press
    tick(2);
    new_game();
    chk("restart_win_clr", win, 0);
    chk("restart_round", round, 0);
    check_playback(1, 1'b0);
    tick(GAP_CYCLES + $urandom_range(0, 3));
    btn_valid = 1'b1;
    btn_num   = exp_seq[0] + 2'($urandom_range(1, 3));
    tick();
    btn_valid = 1'b0;
    chk("chk_lose_pending", lose, 0);
    chk("chk_busy_pending", busy, 1);
    tick();
    chk("lose_flag", lose, 1);
    chk("lose_busy", busy, 0);
    chk("lose_round", round, 1);
    chk("lose_win", win, 0);

    // start clears lose; reset during the first LED pulse
    new_game();
    chk("restart_lose_clr", lose, 0);
    b = 0;
    while (led_en !== 1'b1 && b < 200) begin
      tick();
      b++;
    end
    chk("rst_game_led_rise", led_en, 1);
    tick($urandom_range(1, 5));
    reset_n = 1'b0;
    tick();
    chk("midrst_led_en", led_en, 0);
    chk("midrst_round", round, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rw", mif.mem_rw, 0);
    reset_n = 1'b1;
    m_lfsr = SEED;
    tick(3);
    chk("midrst_idle_busy", busy, 0);

    // after reset the colour sequence restarts from the seed
    new_game();
    check_playback(1, 1'b0);
`ifdef INPUT_TIMEOUT_EN
    b = 0;
    while (lose !== 1'b1 && b < 200) begin
      tick();
      b++;
    end
    chk("timeout_lose", lose, 1);
    chk("timeout_cycle", cyc, last_fall + GAP_CYCLES + TIMEOUT_CYCLES);
    chk("timeout_busy", busy, 0);
`else
    tick(GAP_CYCLES + 60);
    chk("nowait_lose", lose, 0);
    chk("nowait_busy", busy, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
